// File: rtl/cmag_estimator.sv
// Alpha-max-plus-beta-min complex magnitude estimator: three-stage pipeline
// with a per-sample coefficient mode, sideband tag and valid/ready flow control.
module cmag_estimator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ivalid,
  output logic                 iready,
  input  logic [WIDTH-1:0]     i,
  input  logic [WIDTH-1:0]     q,
  input  logic [1:0]           mode,
  input  logic [TAG_WIDTH-1:0] itag,
  output logic                 ovalid,
  input  logic                 oready,
  output logic [WIDTH-1:0]     modulus,
  output logic [TAG_WIDTH-1:0] otag
);

  localparam int unsigned IW = WIDTH + 2;

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_abs_i;
  logic [WIDTH-1:0]     r_s1_abs_q;
  logic [1:0]           r_s1_mode;
  logic [TAG_WIDTH-1:0] r_s1_tag;

  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_s2_mx;
  logic [WIDTH-1:0]     r_s2_mn;
  logic [1:0]           r_s2_mode;
  logic [TAG_WIDTH-1:0] r_s2_tag;

  logic                 r_s3_valid;
  logic [WIDTH-1:0]     r_s3_mod;
  logic [TAG_WIDTH-1:0] r_s3_tag;

  logic                 w_en;
  logic [WIDTH-1:0]     w_abs_i;
  logic [WIDTH-1:0]     w_abs_q;
  logic [WIDTH-1:0]     w_mx;
  logic [WIDTH-1:0]     w_mn;
  logic [IW-1:0]        w_mx_x;
  logic [IW-1:0]        w_mn_x;
  logic [IW-1:0]        w_m3;
  logic [IW-1:0]        w_sum;

  // Whole pipeline advances together whenever the output slot is free or draining.
  assign w_en   = ~r_s3_valid | oready;
  assign iready = w_en;

  // Two's-complement negation; the most negative input lands on 2^(WIDTH-1) unsigned.
  assign w_abs_i = i[WIDTH-1] ? WIDTH'(~i + WIDTH'(1)) : i;
  assign w_abs_q = q[WIDTH-1] ? WIDTH'(~q + WIDTH'(1)) : q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_abs_i <= '0;
      r_s1_abs_q <= '0;
      r_s1_mode  <= '0;
      r_s1_tag   <= '0;
    end else if (w_en) begin
      r_s1_valid <= ivalid;
      r_s1_abs_i <= w_abs_i;
      r_s1_abs_q <= w_abs_q;
      r_s1_mode  <= mode;
      r_s1_tag   <= itag;
    end
  end

  assign w_mx = (r_s1_abs_i >= r_s1_abs_q) ? r_s1_abs_i : r_s1_abs_q;
  assign w_mn = (r_s1_abs_i >= r_s1_abs_q) ? r_s1_abs_q : r_s1_abs_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_mx    <= '0;
      r_s2_mn    <= '0;
      r_s2_mode  <= '0;
      r_s2_tag   <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_mx    <= w_mx;
      r_s2_mn    <= w_mn;
      r_s2_mode  <= r_s1_mode;
      r_s2_tag   <= r_s1_tag;
    end
  end

  // Two guard bits keep every intermediate term positive and unwrapped.
  assign w_mx_x = IW'(r_s2_mx);
  assign w_mn_x = IW'(r_s2_mn);
  assign w_m3   = w_mx_x - (w_mx_x >> 3) + (w_mn_x >> 1);

  always_comb begin
    w_sum = '0;
    case (r_s2_mode)
      2'd0:    w_sum = w_mx_x + (w_mn_x >> 2);
      2'd1:    w_sum = w_mx_x + (w_mn_x >> 1);
      2'd2:    w_sum = w_mx_x - (w_mx_x >> 4) + (w_mn_x >> 1) - (w_mn_x >> 5);
      default: w_sum = (w_m3 > w_mx_x) ? w_m3 : w_mx_x;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s3_valid <= 1'b0;
      r_s3_mod   <= '0;
      r_s3_tag   <= '0;
    end else if (w_en) begin
      r_s3_valid <= r_s2_valid;
      r_s3_mod   <= WIDTH'(w_sum);
      r_s3_tag   <= r_s2_tag;
    end
  end

  assign ovalid  = r_s3_valid;
  assign modulus = r_s3_mod;
  assign otag    = r_s3_tag;

endmodule

// File: tb/tb_cmag_estimator.sv
// Bench for cmag_estimator: directed literal cases plus randomized traffic
// checked every cycle against an in-order queue model of the estimator.
module tb_cmag_estimator;

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 8;

  logic          clock;
  logic          reset;
  logic          ivalid;
  logic          iready;
  logic [W-1:0]  i;
  logic [W-1:0]  q;
  logic [1:0]    mode;
  logic [TW-1:0] itag;
  logic          ovalid;
  logic          oready;
  logic [W-1:0]  modulus;
  logic [TW-1:0] otag;

  cmag_estimator #(.WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready),
    .i(i), .q(q), .mode(mode), .itag(itag),
    .ovalid(ovalid), .oready(oready), .modulus(modulus), .otag(otag)
  );

  typedef struct {
    int mod;
    int tag;
    int age;
    bit has_lit;
    int lit;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   ready_mode = 0;
  bit   cur_has_lit = 0;
  int   cur_lit = 0;
  bit   sending = 0;
  bit   hold = 0;
  int   h_mod = 0;
  int   h_tag = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: magnitude estimate straight from the coefficient formulas.
  function automatic int est(input int si, input int sq, input int m);
    int ai, aq, mx, mn, t;
    ai = (si < 0) ? -si : si;
    aq = (sq < 0) ? -sq : sq;
    mx = (ai > aq) ? ai : aq;
    mn = (ai > aq) ? aq : ai;
    case (m)
      0: est = mx + mn / 4;
      1: est = mx + mn / 2;
      2: est = mx - mx / 16 + mn / 2 - mn / 32;
      default: begin
        t = mx - mx / 8 + mn / 2;
        est = (t > mx) ? t : mx;
      end
    endcase
  endfunction

  // Output-side ready pattern: 0 always ready, 1 random, 2 stalled.
  always @(posedge clock) begin
    #2;
    case (ready_mode)
      0: oready = 1'b1;
      1: oready = 1'($urandom_range(0, 1));
      default: oready = 1'b0;
    endcase
  end

  // Per-cycle compare process; a sample is due at the output after three enabled cycles.
  always @(negedge clock) begin
    bit   exp_v;
    bit   en_m;
    exp_t e;
    if (reset) begin
      exp_q.delete();
      hold = 0;
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].age >= 3);
      en_m  = !exp_v || oready;
      chk("ovalid", int'(ovalid), int'(exp_v));
      chk("iready", int'(iready), int'(en_m));
      if (hold) begin
        chk("hold_modulus", int'(modulus), h_mod);
        chk("hold_otag", int'(otag), h_tag);
      end
      hold  = ovalid && !oready;
      h_mod = int'(modulus);
      h_tag = int'(otag);
      if (exp_v && oready) begin
        e = exp_q.pop_front();
        chk("modulus", int'(modulus), e.mod);
        chk("otag", int'(otag), e.tag);
        if (e.has_lit) chk("modulus_literal", int'(modulus), e.lit);
      end
      if (en_m) begin
        foreach (exp_q[k]) exp_q[k].age++;
      end
      if (ivalid && iready) begin
        e.mod     = est(int'($signed(i)), int'($signed(q)), int'(mode));
        e.tag     = int'(itag);
        e.age     = 1;
        e.has_lit = cur_has_lit;
        e.lit     = cur_lit;
        exp_q.push_back(e);
        acc_cnt++;
      end
    end
  end

  task automatic send(input int si, input int sq, input int sm, input int st,
                      input bit hl, input int lit);
    bit acc;
    int n;
    i           = W'(si);
    q           = W'(sq);
    mode        = 2'(sm);
    itag        = TW'(st);
    cur_has_lit = hl;
    cur_lit     = lit;
    ivalid      = 1'b1;
    acc = 0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clock);
      acc = iready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    ivalid      = 1'b0;
    cur_has_lit = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    ready_mode = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int start;
    int n;
    reset  = 1'b1;
    ivalid = 1'b0;
    oready = 1'b1;
    i = '0; q = '0; mode = '0; itag = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_iready", int'(iready), 1);
    chk("reset_ovalid", int'(ovalid), 0);
    chk("reset_modulus", int'(modulus), 0);
    chk("reset_otag", int'(otag), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    // Classic 3-4-5 vector and the most negative corner, all four modes.
    send(3000, 4000, 0, 8'h11, 1, 4750);
    send(3000, 4000, 1, 8'h11, 1, 5500);
    send(3000, 4000, 2, 8'h11, 1, 5157);
    send(3000, 4000, 3, 8'h11, 1, 5000);
    send(-32768, -32768, 0, 8'h21, 1, 40960);
    send(-32768, -32768, 1, 8'h22, 1, 49152);
    send(-32768, -32768, 2, 8'h23, 1, 46080);
    send(-32768, -32768, 3, 8'h24, 1, 45056);
    send(0, -5, 0, 8'h31, 1, 5);
    send(-7, 7, 1, 8'h32, 1, 10);
    send(0, 0, 2, 8'h33, 1, 0);
    send(0, 0, 3, 8'h34, 1, 0);
    drain();

    // Randomized stream with random output backpressure and input gaps.
    ready_mode = 1;
    for (int k = 0; k < 220; k++) begin
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 0, 0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    // Full stall: only the three pipeline slots fill, then release.
    ready_mode = 2;
    oready     = 1'b0;
    start      = acc_cnt;
    sending    = 1;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(100 * k + 50, -30 * k, k % 4, 8'h40 + k, 0, 0);
        sending = 0;
      end
    join_none
    repeat (10) @(posedge clock);
    #1;
    chk("stall_accepted", acc_cnt - start, 3);
    chk("stall_iready", int'(iready), 0);
    ready_mode = 0;
    oready     = 1'b1;
    n = 0;
    while (sending && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("stall_sender_done", int'(sending), 0);
    drain();

    // Reset with three samples in flight.
    send(1234, -4321, 0, 8'h51, 0, 0);
    send(-222, 999, 1, 8'h52, 0, 0);
    send(5000, 5000, 2, 8'h53, 0, 0);
    chk("pre_reset_ovalid", int'(ovalid), 1);
    reset = 1'b1;
    #1;
    chk("midreset_ovalid", int'(ovalid), 0);
    chk("midreset_modulus", int'(modulus), 0);
    chk("midreset_otag", int'(otag), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1);
    send(3000, 4000, 0, 8'h61, 1, 4750);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmag_estimator.md
Name: cmag_estimator

Overview:
Pipelined complex-magnitude estimator using the alpha-max-plus-beta-min method, with a runtime-selectable coefficient mode.
- Generalised in width; carries a per-sample tag alongside the data.
- Supports valid/ready backpressure on both sides.
- Sits after the DDC/IQ source and feeds envelope detection, AGC and power measurement.

Parameters:
WIDTH, 16, signed I/Q input width; unsigned modulus output width.
TAG_WIDTH, 8, width of the sideband tag carried with each sample (minimum 1).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
ivalid  input  1  input sample valid
iready  output  1  block can accept a sample this cycle
i  input  WIDTH  signed in-phase component
q  input  WIDTH  signed quadrature component
mode  input  2  coefficient mode, sampled with each accepted sample
itag  input  TAG_WIDTH  sideband tag, sampled with each accepted sample
ovalid  output  1  output sample valid
oready  input  1  downstream accepts output this cycle
modulus  output  WIDTH  unsigned magnitude estimate
otag  output  TAG_WIDTH  tag of the sample on modulus

Behaviour:
- Interface: one clock `clock`. Reset `reset` is asynchronous and active-high.
- Reset: all stage valids, modulus, otag and internal registers go to 0. ovalid=0, so iready=1 during and after reset.
- Pipeline: three register stages, S1→S2→S3. Each stage holds a valid bit plus data, mode and tag.
  - S1: abs_i = |i|, abs_q = |q|, computed as WIDTH-bit unsigned values. -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly, with no saturation.
  - S2: mx = max(abs_i, abs_q), mn = min(abs_i, abs_q). On a tie, mx = mn = that value.
  - S3: combine per the sampled mode, all shifts truncating (floor), internal width WIDTH+2. The result always fits in WIDTH unsigned bits; no clipping is required.
    - mode 0: mx + (mn>>2)
    - mode 1: mx + (mn>>1)
    - mode 2: mx - (mx>>4) + (mn>>1) - (mn>>5)
    - mode 3: max(mx, mx - (mx>>3) + (mn>>1))
  - The S3 registers drive modulus, otag and ovalid directly.
- Handshake:
  - Global advance enable en = ~ovalid | oready; iready = en (combinational).
  - A transfer occurs on a cycle where ivalid & iready, or ovalid & oready.
  - When en=1, every stage loads from its predecessor. S1 valid loads ivalid & iready. Bubbles propagate.
  - When en=0, all stages hold, and modulus/otag/ovalid stay stable.
- Latency and throughput:
  - Latency is exactly 3 cycles from input acceptance to ovalid when oready is held high.
  - Throughput is 1 sample/cycle with no bubbles.
- mode and itag are captured per sample. Changing mode between samples takes effect only for later samples, with no flush.
- Simultaneous output consumption and input acceptance in one cycle is legal and loses no data.
- Invalid stage contents: datapath registers may update, but ovalid must never assert for a bubble.
- Reset mid-operation: all in-flight samples are discarded, and ovalid drops asynchronously.
- If ivalid is high while iready is low, the sample is not taken. The source must hold it.

Test Plan:
1. i=3000, q=4000, itag=0x11, modes 0..3 back-to-back, oready=1 → modulus 4750, 5500, 5157, 5000 on consecutive cycles, first 3 cycles after first accept; otag follows.
2. i=-32768, q=-32768 (WIDTH=16), modes 0..3 → 40960, 49152, 46080, 45056; no wrap.
3. i=0, q=-5 mode 0 → 5. i=-7, q=7 mode 1 → 10. i=0, q=0 any mode → 0.
4. Continuous stream of 20 samples with oready toggling randomly → iready = ~ovalid | oready every cycle; outputs in order, none dropped or duplicated; modulus/otag stable while ovalid & ~oready.
5. oready=0 for 10 cycles with ivalid=1 → exactly 3 samples accepted, then iready=0. On oready=1, the 3 are drained in order and new inputs are accepted in the same cycles.
6. Assert reset for 1 cycle with 3 samples in flight → ovalid=0 immediately, modulus=0, otag=0. The next accepted sample appears after exactly 3 cycles.
